// File: rtl/mod_inverse.sv
// mod_inverse: modular inverse of a mod modulo using extended Euclid.
// Each Euclid step runs a WIDTH-cycle restoring divider, then one cycle to update the Bezout coefficients.
module mod_inverse #(
  parameter int WIDTH = 10
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] modulo,
  input  logic             valid_in,
  output logic [WIDTH-1:0] c_out,
  output logic             valid_out,
  output logic             error_out,
  output logic             busy_out
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {IDLE, CHECK, DIVIDE, UPDATE, FIXUP, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] m, r0, r1, quo, rem;
  logic signed [WIDTH+1:0] t0, t1;
  logic [CW-1:0] cnt;
  logic err;
  logic [WIDTH:0] sh;
  logic [WIDTH+1:0] diff;
  // quo starts as the dividend and shifts quotient bits in from the right
  assign sh = {rem, quo[WIDTH-1]};
  assign diff = {1'b0, sh} - {2'b0, r1};
  assign valid_out = state == DONE;
  assign error_out = valid_out & err;
  assign busy_out = state != IDLE;
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state == IDLE   ? (valid_in ? (modulo < WIDTH'(2) ? DONE : CHECK) : IDLE) :
              state == CHECK  ? (r1 == '0 ? FIXUP : DIVIDE) :
              state == DIVIDE ? (cnt == CW'(WIDTH - 1) ? UPDATE : DIVIDE) :
              state == UPDATE ? CHECK :
              state == FIXUP  ? DONE : IDLE;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      c_out <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid_in) begin
          m <= modulo;
          r0 <= modulo;
          r1 <= a;
          t0 <= '0;
          t1 <= (WIDTH + 2)'(1);
          err <= modulo < WIDTH'(2);
          if (modulo < WIDTH'(2)) c_out <= '0;
        end
        CHECK: begin
          quo <= r0;
          rem <= '0;
          cnt <= '0;
        end
        DIVIDE: begin
          quo <= {quo[WIDTH-2:0], ~diff[WIDTH+1]};
          rem <= diff[WIDTH+1] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
          cnt <= cnt + 1'b1;
        end
        UPDATE: begin
          r0 <= r1;
          r1 <= rem;
          t0 <= t1;
          t1 <= t0 - $signed({2'b0, quo}) * t1;
        end
        FIXUP: begin
          err <= r0 != WIDTH'(1);
          c_out <= r0 != WIDTH'(1) ? '0 :
                   t0 < 0 ? WIDTH'(t0 + $signed({2'b0, m})) : WIDTH'(t0);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_inverse.sv
// tb_mod_inverse: scoreboard bench; a brute-force inverse search supplies expected results.
module tb_mod_inverse;
  localparam int W = 10;
  localparam int BOUND = (2 * W + 2) * (W + 2) + 4;
  typedef struct {
    logic err;
    logic cmp_c;
    logic [W-1:0] c;
  } exp_t;
  logic clk_in = 0, rst_in = 1, valid_in = 0;
  logic [W-1:0] a = '0, modulo = '0;
  logic [W-1:0] c_out;
  logic valid_out, error_out, busy_out;
  exp_t sb[$];
  exp_t mon_e;
  int total = 0, bad = 0;

  mod_inverse #(.WIDTH(W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .a(a), .modulo(modulo), .valid_in(valid_in),
    .c_out(c_out), .valid_out(valid_out), .error_out(error_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic exp_t model(int av, int mv);
    exp_t e;
    e.err = 1;
    e.c = '0;
    e.cmp_c = mv >= 2;
    if (mv >= 2)
      for (int d = 0; d < mv; d++)
        if ((av * d) % mv == 1) begin
          e.err = 0;
          e.c = d[W-1:0];
          break;
        end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    if (valid_out) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got valid_out=1 want 0 (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        check("error_out", int'(error_out), int'(mon_e.err));
        if (mon_e.cmp_c) check("c_out", int'(c_out), int'(mon_e.c));
      end
    end else if (error_out) begin
      total++;
      bad++;
      $display("FAIL error_out_idle: got 1 want 0 (t=%0t)", $time);
    end
  end

  // Called at a negedge; returns at the negedge of the cycle after DONE.
  task automatic run(input int av, input int mv, input bit pulse);
    int n;
    bit seen, busy_ok;
    a = W'(av);
    modulo = W'(mv);
    valid_in = 1;
    sb.push_back(model(av, mv));
    @(negedge clk_in);
    valid_in = 0;
    n = 1;
    seen = 0;
    busy_ok = 1;
    while (n <= BOUND + 5 && !seen) begin
      if (!busy_out) busy_ok = 0;
      if (valid_out) seen = 1;
      else begin
        if (pulse && n == 3) begin
          a = W'($urandom);
          modulo = W'($urandom);
          valid_in = 1;
        end else valid_in = 0;
        @(negedge clk_in);
        n++;
      end
    end
    valid_in = 0;
    check("valid_seen", int'(seen), 1);
    check("latency_ok", int'(n <= (mv < 2 ? 3 : BOUND)), 1);
    check("busy_held", int'(busy_ok), 1);
    @(negedge clk_in);
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    check("rst_c_out", int'(c_out), 0);
    check("rst_valid", int'(valid_out), 0);
    check("rst_error", int'(error_out), 0);
    check("rst_busy", int'(busy_out), 0);
    rst_in = 0;
    run(7, 40, 0);
    run(50, 11, 0);
    run(69, 54, 0);
    run(0, 9, 0);
    run(5, 1, 0);
    run(5, 0, 0);
    run(2, 1023, 1);
    a = 3;
    modulo = 11;
    valid_in = 1;
    @(negedge clk_in);
    valid_in = 0;
    repeat (4) @(negedge clk_in);
    rst_in = 1;
    valid_in = 1;
    a = 5;
    modulo = 7;
    @(negedge clk_in);
    rst_in = 0;
    valid_in = 0;
    check("midrst_c_out", int'(c_out), 0);
    check("midrst_busy", int'(busy_out), 0);
    run(3, 11, 1);
    for (int i = 0; i < 40; i++)
      run(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), ($urandom & 1) == 1);
    repeat (5) @(negedge clk_in);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mod_inverse.md
MOD_INVERSE -- requirements
Module: mod_inverse

Interface
REQ-001 The module SHALL have a parameter WIDTH, default 10, giving the operand and result bit width.
REQ-002 The module SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port a, input, WIDTH bits: the value to invert (unsigned).
REQ-005 The module SHALL have port modulo, input, WIDTH bits: the modulus (unsigned).
REQ-006 The module SHALL have port valid_in, input, 1 bit: start request; a and modulo are sampled on this cycle.
REQ-007 The module SHALL have port c_out, output, WIDTH bits: the result d, with 0 <= d < modulo and (a*d) mod modulo = 1.
REQ-008 The module SHALL have port valid_out, output, 1 bit: one-cycle pulse marking c_out/error_out valid.
REQ-009 The module SHALL have port error_out, output, 1 bit: no inverse exists; valid only while valid_out = 1.
REQ-010 The module SHALL have port busy_out, output, 1 bit: high from the cycle after acceptance through the valid_out cycle.

Function
REQ-011 The module SHALL accept valid_in only in IDLE; while busy_out = 1, valid_in SHALL be ignored and the operands SHALL NOT be resampled.
REQ-012 On acceptance the module SHALL load r0 = modulo, r1 = a, t0 = 0, t1 = 1; t registers SHALL be signed, WIDTH+2 bits wide.
REQ-013 On acceptance, if modulo < 2, the module SHALL go directly to DONE with error_out = 1.
REQ-014 The FSM SHALL have states IDLE, CHECK, DIVIDE, UPDATE, FIXUP, DONE.
REQ-015 CHECK: if r1 = 0, the FSM SHALL go to FIXUP; otherwise it SHALL go to DIVIDE.
REQ-016 DIVIDE SHALL be a restoring shift-subtract divider, one quotient bit per cycle, taking exactly WIDTH cycles to produce q = r0 / r1 and rem = r0 mod r1.
REQ-017 UPDATE (1 cycle) SHALL set (r0, r1) <= (r1, rem) and (t0, t1) <= (t1, t0 - q*t1), then return to CHECK.
REQ-018 The case a >= modulo SHALL need no pre-reduction: the first iteration yields q = 0 and swaps the operands.
REQ-019 FIXUP: if r0 != 1 (gcd != 1, including a = 0), the module SHALL set error_out = 1 and c_out = 0.
REQ-020 FIXUP: otherwise the module SHALL set c_out = t0 + modulo when t0 < 0, else t0, truncated to WIDTH bits.
REQ-021 DONE SHALL last exactly 1 cycle: valid_out = 1, error_out as determined, then the FSM returns to IDLE.
REQ-022 A valid_in in the cycle right after DONE SHALL be accepted.
REQ-023 c_out SHALL hold its last value until the next DONE; error_out SHALL be 0 whenever valid_out = 0.
REQ-024 Latency from the acceptance cycle to valid_out SHALL NOT exceed (2*WIDTH+2)*(WIDTH+2)+4 cycles; the exact count is data-dependent.
REQ-025 Intermediate arithmetic SHALL NOT overflow for any WIDTH-bit operands; this holds because |t| <= modulo.

Reset
REQ-026 While rst_in = 1 at a clock edge, the FSM SHALL enter IDLE with c_out = 0, valid_out = 0, error_out = 0, busy_out = 0.
REQ-027 Reset asserted mid-computation SHALL abort the operation with no valid_out pulse; a valid_in in the first cycle after reset deasserts SHALL be accepted.
REQ-028 valid_in asserted during the same cycle as rst_in = 1 SHALL be ignored.

Verification
REQ-029 Basic case: a = 7, modulo = 40 -> one valid_out pulse, c_out = 23, error_out = 0, busy_out high throughout.
REQ-030 Operand larger than the modulus: a = 50, modulo = 11 -> c_out = 2, error_out = 0.
REQ-031 No inverse exists:
  - a = 69, modulo = 54 -> valid_out with error_out = 1, c_out = 0.
  - a = 0, modulo = 9 -> error_out = 1.
REQ-032 Degenerate modulus: modulo = 1 and modulo = 0 (any a) -> valid_out within 3 cycles of acceptance, error_out = 1.
REQ-033 Full width and latency bound: a = 2, modulo = 1023 -> c_out = 512; valid_out arrives within the REQ-024 bound.
REQ-034 Reset and re-accept:
  - Start a = 3, modulo = 11; assert rst_in for 1 cycle mid-DIVIDE -> no valid_out pulse.
  - Then start a = 3, modulo = 11 again -> c_out = 4.
  - valid_in pulsed while busy_out = 1 -> ignored, result unchanged.
